alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer_if.sv | 33 +++
 rtl/alu_cmd_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Request, ALU-bus and response signals of alu_cmd_sequencer.
// slave is the sequencer's own view; master is the environment that drives it.
interface alu_cmd_sequencer_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [7:0]  req_a_in;
  logic [7:0]  req_b_in;
  logic [3:0]  req_cmd_in;
  logic [7:0]  alu_a_out;
  logic [7:0]  alu_b_out;
  logic [3:0]  alu_cmd_out;
  logic        alu_oe_out;
  logic [15:0] alu_d_in;
  logic        rsp_valid_out;
  logic        rsp_ready_in;
  logic [15:0] rsp_data_out;
  logic [3:0]  rsp_cmd_out;
  logic        rsp_err_out;
  logic        busy_out;
  logic [15:0] op_count_out;

  modport slave (
    input  req_valid_in, req_a_in, req_b_in, req_cmd_in, alu_d_in, rsp_ready_in,
    output req_ready_out, alu_a_out, alu_b_out, alu_cmd_out, alu_oe_out,
           rsp_valid_out, rsp_data_out, rsp_cmd_out, rsp_err_out, busy_out, op_count_out
  );

  modport master (
    output req_valid_in, req_a_in, req_b_in, req_cmd_in, alu_d_in, rsp_ready_in,
    input  req_ready_out, alu_a_out, alu_b_out, alu_cmd_out, alu_oe_out,
           rsp_valid_out, rsp_data_out, rsp_cmd_out, rsp_err_out, busy_out, op_count_out
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Sequences one request at a time through an external ALU: drive operands, wait, sample, respond.
// Define ALU_SEQ_DIVZ_EN to trap DIV-by-zero locally instead of running it on the ALU.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_cmd_sequencer_if.slave bus
);
  // TRAP is only reachable when the divide-by-zero trap is compiled in.
  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, RESP, TRAP} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  localparam logic [3:0] CMD_DIV     = 4'h5;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [3:0]  alu_cmd_q, alu_cmd_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic [3:0]  rsp_cmd_q, rsp_cmd_d;
  logic [15:0] op_count_q, op_count_d;
  logic        accept;
  logic        divz;
  logic        req_ready, alu_oe, rsp_valid, busy;

  assign accept = (state_q == IDLE) && bus.req_valid_in;

`ifdef ALU_SEQ_DIVZ_EN
  assign divz = (bus.req_cmd_in == CMD_DIV) && (bus.req_b_in == 8'h00);
`else
  assign divz = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = divz ? TRAP : DRIVE;
      DRIVE:   if (cnt_q <= 4'd1) state_d = SAMPLE;
      SAMPLE:  state_d = RESP;
      RESP:    if (bus.rsp_ready_in) state_d = IDLE;
      TRAP:    state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    alu_oe    = (state_q == DRIVE) || (state_q == SAMPLE);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_cmd_d  = alu_cmd_q;
    rsp_data_d = rsp_data_q;
    rsp_cmd_d  = rsp_cmd_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: if (accept) begin
        alu_a_d   = bus.req_a_in;
        alu_b_d   = bus.req_b_in;
        alu_cmd_d = bus.req_cmd_in;
        cnt_d     = SETTLE_INIT;
      end
      DRIVE:  cnt_d = cnt_q - 4'd1;
      SAMPLE: begin
        rsp_data_d = bus.alu_d_in;
        rsp_cmd_d  = alu_cmd_q;
      end
      TRAP: begin
        rsp_data_d = 16'hFFFF;
        rsp_cmd_d  = alu_cmd_q;
      end
      RESP: if (bus.rsp_ready_in) op_count_d = op_count_q + 16'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cmd_q  <= '0;
      rsp_data_q <= '0;
      rsp_cmd_q  <= '0;
      op_count_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_cmd_q  <= alu_cmd_d;
      rsp_data_q <= rsp_data_d;
      rsp_cmd_q  <= rsp_cmd_d;
      op_count_q <= op_count_d;
    end
  end

`ifdef ALU_SEQ_DIVZ_EN
  // Error flag describes the response currently held, so every capture rewrites it.
  logic rsp_err_q, rsp_err_d;

  always_comb begin
    rsp_err_d = rsp_err_q;
    if (state_q == SAMPLE)    rsp_err_d = 1'b0;
    else if (state_q == TRAP) rsp_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_err_q <= 1'b0;
    else        rsp_err_q <= rsp_err_d;
  end

  assign bus.rsp_err_out = rsp_err_q;
`else
  assign bus.rsp_err_out = 1'b0;
`endif

  assign bus.req_ready_out = req_ready;
  assign bus.alu_oe_out    = alu_oe;
  assign bus.rsp_valid_out = rsp_valid;
  assign bus.busy_out      = busy;
  assign bus.alu_a_out     = alu_a_q;
  assign bus.alu_b_out     = alu_b_q;
  assign bus.alu_cmd_out   = alu_cmd_q;
  assign bus.rsp_data_out  = rsp_data_q;
  assign bus.rsp_cmd_out   = rsp_cmd_q;
  assign bus.op_count_out  = op_count_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized bench for alu_cmd_sequencer: two instances (settle 1 and 4) checked against a transaction-level model.
// Follows ALU_SEQ_DIVZ_EN the same way the design does.
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_SEQ_DIVZ_EN
  localparam bit DIVZ_ON = 1'b1;
`else
  localparam bit DIVZ_ON = 1'b0;
`endif

  alu_cmd_sequencer_if bus1();
  alu_cmd_sequencer_if bus4();

  alu_cmd_sequencer #(.SETTLE_CYCLES(1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_cmd_sequencer #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  logic       req_valid, rsp_ready, sel4;
  logic [7:0] req_a, req_b;
  logic [3:0] req_cmd;

  assign bus1.req_valid_in = req_valid & ~sel4;
  assign bus4.req_valid_in = req_valid & sel4;
  assign bus1.rsp_ready_in = rsp_ready & ~sel4;
  assign bus4.rsp_ready_in = rsp_ready & sel4;
  assign bus1.req_a_in = req_a;
  assign bus4.req_a_in = req_a;
  assign bus1.req_b_in = req_b;
  assign bus4.req_b_in = req_b;
  assign bus1.req_cmd_in = req_cmd;
  assign bus4.req_cmd_in = req_cmd;

  // Environment ALU: 0 ADD, 1 SUB, 2 MUL, 5 DIV, F BUFF, anything else a mix of the operands.
  function automatic logic [15:0] alu_fn(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      4'h0:    return {8'h00, a} + {8'h00, b};
      4'h1:    return {8'h00, a} - {8'h00, b};
      4'h2:    return {8'h00, a} * {8'h00, b};
      4'h5:    return (b == 8'h00) ? 16'h0BAD : {8'h00, a / b};
      4'hF:    return {8'h00, a};
      default: return {a, b} ^ {12'h000, c};
    endcase
  endfunction

  // The ALU result is only valid once operands have been driven for the settle time.
  int oe_cyc1 = 0, oe_cyc4 = 0;
  always @(posedge clk) begin
    oe_cyc1 <= bus1.alu_oe_out ? oe_cyc1 + 1 : 0;
    oe_cyc4 <= bus4.alu_oe_out ? oe_cyc4 + 1 : 0;
  end
  assign bus1.alu_d_in = (bus1.alu_oe_out && oe_cyc1 == 1) ?
                         alu_fn(bus1.alu_cmd_out, bus1.alu_a_out, bus1.alu_b_out) : 16'hDEAD;
  assign bus4.alu_d_in = (bus4.alu_oe_out && oe_cyc4 == 4) ?
                         alu_fn(bus4.alu_cmd_out, bus4.alu_a_out, bus4.alu_b_out) : 16'hDEAD;

  logic        obs_ready, obs_oe, obs_valid, obs_err, obs_busy;
  logic [7:0]  obs_a, obs_b;
  logic [3:0]  obs_cmd, obs_rcmd;
  logic [15:0] obs_data, obs_count;
  assign obs_ready = sel4 ? bus4.req_ready_out : bus1.req_ready_out;
  assign obs_oe    = sel4 ? bus4.alu_oe_out    : bus1.alu_oe_out;
  assign obs_valid = sel4 ? bus4.rsp_valid_out : bus1.rsp_valid_out;
  assign obs_err   = sel4 ? bus4.rsp_err_out   : bus1.rsp_err_out;
  assign obs_busy  = sel4 ? bus4.busy_out      : bus1.busy_out;
  assign obs_a     = sel4 ? bus4.alu_a_out     : bus1.alu_a_out;
  assign obs_b     = sel4 ? bus4.alu_b_out     : bus1.alu_b_out;
  assign obs_cmd   = sel4 ? bus4.alu_cmd_out   : bus1.alu_cmd_out;
  assign obs_rcmd  = sel4 ? bus4.rsp_cmd_out   : bus1.rsp_cmd_out;
  assign obs_data  = sel4 ? bus4.rsp_data_out  : bus1.rsp_data_out;
  assign obs_count = sel4 ? bus4.op_count_out  : bus1.op_count_out;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] cmd;
    int         stall;
  } op_t;

  op_t         ops[$];
  logic [15:0] exp_count [2];

  task automatic scramble();
    req_valid = 1'($urandom_range(0, 1));
    req_a     = 8'($urandom);
    req_b     = 8'($urandom);
    req_cmd   = 4'($urandom);
  endtask

  task automatic drive_req(input op_t o);
    req_valid = 1'b1;
    req_a     = o.a;
    req_b     = o.b;
    req_cmd   = o.cmd;
  endtask

  task automatic add_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd, input int stall);
    op_t o;
    o.a = a; o.b = b; o.cmd = cmd; o.stall = stall;
    ops.push_back(o);
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) b = 8'h00;
      add_op(8'($urandom), b, 4'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  // Runs the queued ops back to back; each next request is presented during the previous handshake.
  task automatic run_ops();
    int settle;
    int k;
    settle = sel4 ? 4 : 1;
    k      = sel4 ? 1 : 0;
    @(negedge clk);
    drive_req(ops[0]);
    for (int i = 0; i < ops.size(); i++) begin
      op_t         o;
      bit          divz;
      logic [15:0] exp_data;
      int          lat;
      int          oe_seen;
      o        = ops[i];
      divz     = DIVZ_ON && (o.cmd == 4'h5) && (o.b == 8'h00);
      exp_data = divz ? 16'hFFFF : alu_fn(o.cmd, o.a, o.b);
      lat      = 0;
      oe_seen  = 0;
      check("ready_in_idle", obs_ready, 1);
      @(negedge clk);
      scramble();
      check("alu_a", obs_a, o.a);
      check("alu_b", obs_b, o.b);
      check("alu_cmd", obs_cmd, o.cmd);
      check("busy_after_accept", obs_busy, 1);
      while (!obs_valid && lat < 40) begin
        if (obs_oe) oe_seen++;
        @(negedge clk);
        scramble();
        lat++;
      end
      check("latency", lat, divz ? 1 : settle + 1);
      check("oe_cycles", oe_seen, divz ? 0 : settle + 1);
      check("rsp_data", obs_data, exp_data);
      check("rsp_cmd", obs_rcmd, o.cmd);
      check("rsp_err", obs_err, divz);
      for (int s = 0; s < o.stall; s++) begin
        @(negedge clk);
        scramble();
        req_valid = 1'b1;
        check("stall_valid", obs_valid, 1);
        check("stall_data", obs_data, exp_data);
        check("stall_ready", obs_ready, 0);
        check("stall_oe", obs_oe, 0);
      end
      rsp_ready = 1'b1;
      if (i + 1 < ops.size()) drive_req(ops[i + 1]);
      else req_valid = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_count[k] = exp_count[k] + 16'd1;
      $display("op %0d dut%0d cmd=%h a=%h b=%h -> data=%h err=%0d lat=%0d count=%h",
               i, settle, o.cmd, o.a, o.b, obs_data, obs_err, lat, obs_count);
      check("op_count", obs_count, exp_count[k]);
      check("valid_after_hs", obs_valid, 0);
      check("data_hold", obs_data, exp_data);
    end
  endtask

  initial begin
    req_valid = 1'b0; rsp_ready = 1'b0; sel4 = 1'b0;
    req_a = '0; req_b = '0; req_cmd = '0;
    exp_count[0] = '0; exp_count[1] = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", obs_ready, 1);
    check("rst_busy", obs_busy, 0);
    check("rst_oe", obs_oe, 0);
    check("rst_valid", obs_valid, 0);
    check("rst_count", obs_count, 0);
    check("rst_data", obs_data, 0);
    check("rst_alu_a", obs_a, 0);
    #2 rst_n = 1'b1;

    add_op(8'h05, 8'h03, 4'h0, 0);
    add_op(8'h10, 8'h01, 4'h1, 5);
    add_op(8'h20, 8'h00, 4'h5, 1);
    add_op(8'h7A, 8'h00, 4'hF, 0);
    add_random(40);
    run_ops();

    // Reset while operands are being driven: bus released without any clock edge.
    @(negedge clk);
    req_valid = 1'b1; req_a = 8'h33; req_b = 8'h44; req_cmd = 4'h0;
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_oe", obs_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_oe", obs_oe, 0);
    check("mid_rst_busy", obs_busy, 0);
    check("mid_rst_valid", obs_valid, 0);
    check("mid_rst_count", obs_count, 0);
    check("mid_rst_ready", obs_ready, 1);
    #1 rst_n = 1'b1;
    exp_count[0] = '0; exp_count[1] = '0;
    $display("async reset during DRIVE applied");

    // Counter wrap: start just below the top instead of running 65535 operations.
    @(negedge clk);
    force dut.op_count_q = 16'hFFFE;
    #1 release dut.op_count_q;
    exp_count[0] = 16'hFFFE;
    ops.delete();
    add_op(8'h01, 8'h01, 4'h0, 0);
    add_op(8'h09, 8'h04, 4'h1, 1);
    run_ops();

    @(negedge clk);
    sel4 = 1'b1;
    ops.delete();
    add_op(8'hFF, 8'hFF, 4'h2, 0);
    add_op(8'h20, 8'h00, 4'h5, 2);
    add_random(8);
    run_ops();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
